// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among N requesters,
// with read-return routing and a full-memory clear sequencer.
module ram_access_arbiter #(
  parameter int N      = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  busy,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          wr,
  input  logic [N*ADDR_W-1:0]   addr,
  input  logic [N*DATA_W-1:0]   wdata,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W-1:0]     ram_data,
  output logic                  ram_wren,
  input  logic [DATA_W-1:0]     ram_q
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_IDLE, S_CLEARING} state_t;

  state_t                        r_state, w_state_nxt;
  logic [ADDR_W:0]               r_cnt;
  logic [IDX_W-1:0]              r_ptr, r_gidx, w_win, w_ptr_nxt;
  logic [N-1:0]                  r_gnt, w_elig;
  logic                          w_found, w_last;
  logic [ADDR_W-1:0]             r_addr;
  logic [DATA_W-1:0]             r_data;
  logic                          r_wren;
  logic [RD_LAT-1:0]             r_tag_vld;
  logic [RD_LAT-1:0][IDX_W-1:0]  r_tag_idx;

  assign w_last      = (r_cnt == (ADDR_W+1)'(DEPTH-1));
  assign busy        = (r_state == S_CLEARING);
  assign gnt         = r_gnt;
  assign ram_address = r_addr;
  assign ram_data    = r_data;
  assign ram_wren    = r_wren;
  assign rdata       = ram_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (clear)  w_state_nxt = S_CLEARING;
      S_CLEARING: if (w_last) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Masking the current grant holder limits each requester to one slot per two cycles.
  always_comb begin
    w_elig  = req & ~r_gnt;
    w_found = 1'b0;
    w_win   = '0;
    for (int o = 0; o < N; o++) begin
      if (!w_found && w_elig[(int'(r_ptr) + o) % N]) begin
        w_found = 1'b1;
        w_win   = IDX_W'((int'(r_ptr) + o) % N);
      end
    end
    w_ptr_nxt = (w_win == IDX_W'(N-1)) ? '0 : w_win + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_gnt     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wren    <= 1'b0;
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      // Tag pipe keeps running during a clear so earlier reads still return.
      r_tag_vld[0] <= (|r_gnt) & ~r_wren;
      r_tag_idx[0] <= r_gidx;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end

      if (r_state == S_CLEARING) begin
        r_addr <= r_cnt[ADDR_W-1:0];
        r_data <= '0;
        r_wren <= 1'b1;
        r_gnt  <= '0;
        r_cnt  <= r_cnt + 1'b1;
      end else if (clear) begin
        r_cnt  <= '0;
        r_gnt  <= '0;
        r_wren <= 1'b0;
      end else if (w_found) begin
        r_addr <= addr[w_win*ADDR_W +: ADDR_W];
        r_data <= wdata[w_win*DATA_W +: DATA_W];
        r_wren <= wr[w_win];
        r_gnt  <= N'(1) << w_win;
        r_gidx <= w_win;
        r_ptr  <= w_ptr_nxt;
      end else begin
        r_gnt  <= '0;
        r_wren <= 1'b0;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (r_tag_vld[RD_LAT-1]) rvalid[r_tag_idx[RD_LAT-1]] = 1'b1;
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a 2-cycle-latency RAM model.
module tb_ram_access_arbiter;
  logic        clock = 1'b0;
  logic        reset, clear, busy, reload;
  logic [2:0]  req, wr, gnt, rvalid;
  logic [14:0] addr;
  logic [29:0] wdata;
  logic [9:0]  rdata, ram_data, ram_q, r_q1;
  logic [4:0]  ram_address;
  logic        ram_wren;
  logic [9:0]  mem [32];

  int n_chk = 0, n_fail = 0;

  ram_access_arbiter #(.N(3), .ADDR_W(5), .DATA_W(10), .RD_LAT(2)) dut (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy),
    .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] initv(int i);
    return 10'(i * 37 + 5);
  endfunction

  // RAM model: q valid two cycles after the address is presented.
  always @(posedge clock) begin
    r_q1  <= mem[ram_address];
    ram_q <= r_q1;
    if (reload) begin
      for (int i = 0; i < 32; i++) mem[i] <= initv(i);
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clock);
  endtask

  int nb, nw, bad, nz;

  initial begin
    reset = 1'b1; reload = 1'b1; clear = 1'b0;
    req = '0; wr = '0; addr = '0; wdata = '0;
    nclk(); nclk();

    // reset release with all three requesting reads
    reload = 1'b0; reset = 1'b0;
    req = 3'b111;
    addr[0 +: 5] = 5'd3; addr[5 +: 5] = 5'd9; addr[10 +: 5] = 5'd17;
    nclk();
    chk("rr_g0", gnt, 3'b001); chk("rr_a0", ram_address, 5'd3); chk("rr_wren", ram_wren, 1'b0);
    nclk();
    chk("rr_g1", gnt, 3'b010); chk("rr_a1", ram_address, 5'd9);
    nclk();
    chk("rr_g2", gnt, 3'b100); chk("rr_a2", ram_address, 5'd17);
    chk("rv0", rvalid, 3'b001); chk("rd0", rdata, initv(3));
    nclk();
    chk("rr_g3", gnt, 3'b001);
    chk("rv1", rvalid, 3'b010); chk("rd1", rdata, initv(9));

    // async reset mid-cycle
    reset = 1'b1;
    #1;
    chk("rst_gnt", gnt, 3'b000); chk("rst_rv", rvalid, 3'b000);
    chk("rst_busy", busy, 1'b0); chk("rst_wren", ram_wren, 1'b0);
    chk("rst_addr", ram_address, 5'd0);
    nclk();
    reset = 1'b0;
    nclk();
    chk("rst_first_gnt", gnt, 3'b001);
    req = '0;
    nclk();
    chk("idle_gnt", gnt, 3'b000);
    nclk(); nclk(); nclk();

    // write then read same address
    req = 3'b001; wr = 3'b001; addr[0 +: 5] = 5'd5; wdata[0 +: 10] = 10'h2A5;
    nclk();
    chk("wr_gnt", gnt, 3'b001); chk("wr_wren", ram_wren, 1'b1);
    chk("wr_addr", ram_address, 5'd5); chk("wr_data", ram_data, 10'h2A5);
    req = 3'b010; wr = 3'b000; addr[5 +: 5] = 5'd5;
    nclk();
    chk("rd_gnt", gnt, 3'b010); chk("rd_wren", ram_wren, 1'b0); chk("rd_addr", ram_address, 5'd5);
    req = '0;
    nclk();
    chk("rd_rv_early", rvalid, 3'b000);
    nclk();
    chk("rd_rv", rvalid, 3'b010); chk("rd_data", rdata, 10'h2A5);
    nclk(); nclk();

    // pointer fairness
    req = 3'b001; addr[0 +: 5] = 5'd0;
    nclk();
    chk("pf_g0", gnt, 3'b001);
    req = 3'b011;
    nclk();
    chk("pf_g1", gnt, 3'b010);
    req = 3'b001;
    nclk();
    chk("pf_g0b", gnt, 3'b001);
    req = 3'b100;
    nclk();
    chk("pf_g2", gnt, 3'b100);
    req = 3'b010;
    nclk();
    chk("pf_g1b", gnt, 3'b010);
    req = 3'b000;
    nclk();
    chk("pf_none", gnt, 3'b000);
    nclk(); nclk(); nclk();

    // clear with a pending read; second clear mid-sequence must be ignored
    clear = 1'b1; req = 3'b100; wr = 3'b000; addr[10 +: 5] = 5'd7;
    nclk();
    clear = 1'b0;
    chk("clr_busy", busy, 1'b1);
    nb = 0; nw = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (nb > 0 && !busy) break;
      clear = (i == 5);
      if (busy) nb++;
      if (busy && gnt != 3'b000) bad++;
      if (ram_wren) begin
        if (ram_address != 5'(nw) || ram_data != 10'h000) bad++;
        nw++;
      end
      nclk();
    end
    clear = 1'b0;
    chk("clr_busy_len", nb, 32); chk("clr_seq_bad", bad, 0); chk("clr_nw", nw, 31);
    chk("clr_done", busy, 1'b0);
    chk("clr_last_wren", ram_wren, 1'b1); chk("clr_last_addr", ram_address, 5'd31);
    chk("clr_last_gnt", gnt, 3'b000);
    nclk();
    chk("post_gnt", gnt, 3'b100); chk("post_addr", ram_address, 5'd7);
    req = '0;
    nz = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 10'h000) nz++;
    chk("clr_mem_zero", nz, 0);
    nclk();
    chk("post_rv_early", rvalid, 3'b000);
    nclk();
    chk("post_rv", rvalid, 3'b100); chk("post_rdata", rdata, 10'h000);
    nclk();

    // reset in the middle of a clear
    reload = 1'b1;
    nclk();
    reload = 1'b0;
    clear = 1'b1;
    nclk();
    clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ram_wren && ram_address == 5'd11) break;
      nclk();
    end
    chk("mid_reach", ram_address, 5'd11);
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b0); chk("mid_wren", ram_wren, 1'b0); chk("mid_gnt", gnt, 3'b000);
    nclk();
    reset = 1'b0;
    nclk();
    chk("mid_mem10", mem[10], 10'h000);
    chk("mid_mem12", mem[12], initv(12));
    chk("mid_mem31", mem[31], initv(31));
    clear = 1'b1;
    nclk();
    clear = 1'b0;
    chk("re_busy", busy, 1'b1);
    nclk();
    chk("re_wren", ram_wren, 1'b1); chk("re_addr0", ram_address, 5'd0);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nclk();
    end
    chk("re_done", busy, 1'b0);
    nclk();
    chk("re_mem31", mem[31], 10'h000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
